// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/read bus between execute stage and the mul/div unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [1:0]       hilo_sel;
  logic [WIDTH-1:0] hilo_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, funct, rs_data, rt_data, hilo_sel,
    input  hilo_out, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, funct, rs_data, rt_data, hilo_sel,
    output hilo_out, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          CLK,
  input logic          RESET,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_n;

  // Working registers: acc holds product (mult) or remainder:quotient (div);
  // opb holds the multiplicand or the divisor magnitude.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               sgn_q;
  logic               sgn_r;

  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r;
  logic               load, step_en, fix_en;

  // Operand conditioning at issue time
  logic               legal, is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  assign legal     = (bus.funct[5:2] == 4'b0110);
  assign is_signed = ~bus.funct[0];
  assign rs_neg    = is_signed & bus.rs_data[WIDTH-1];
  assign rt_neg    = is_signed & bus.rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

  // One radix-2 step; the add keeps its carry so it shifts back into the top bit
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_top;
  logic [WIDTH:0]     div_diff;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_top  = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_top - {1'b0, opb};

  // Sign correction of the finished magnitudes
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = sgn_q ? -acc : acc;
  assign quo_fix  = sgn_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && legal) begin
          load    = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (cnt == LAST) state_n = FIX;
      end
      FIX: begin
        fix_en  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Working datapath: latch operands, then iterate shift-add or restoring divide
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
    end else if (load) begin
      is_div <= bus.funct[1];
      sgn_q  <= rs_neg ^ rt_neg;
      sgn_r  <= rs_neg;
      cnt    <= '0;
      acc    <= {{WIDTH{1'b0}}, (bus.funct[1] ? rs_mag : rt_mag)};
      opb    <= bus.funct[1] ? rt_mag : rs_mag;
    end else if (step_en) begin
      cnt <= cnt + 1'b1;
      if (!is_div)
        acc <= {mul_sum, acc[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc <= {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // Architectural HI/LO plus busy/done flags; busy spans the done cycle too
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_n != IDLE) || (state == FIX);
      done_r <= fix_en;
      if (fix_en) begin
        if (!is_div) begin
          hi_r <= prod_fix[2*WIDTH-1:WIDTH];
          lo_r <= prod_fix[WIDTH-1:0];
        end else begin
          // A zero divisor leaves the dividend as remainder; force quotient to all ones
          hi_r <= rem_fix;
          lo_r <= (opb == '0) ? '1 : quo_fix;
        end
      end
    end
  end

  // mfhi/mflo read mux
  always_comb begin
    case (bus.hilo_sel)
      2'b10:   bus.hilo_out = hi_r;
      2'b01:   bus.hilo_out = lo_r;
      default: bus.hilo_out = '0;
    endcase
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.stall = busy_r & ((bus.hilo_sel != 2'b00) | bus.start);
endmodule
